// File: rtl/ifetch_unit.sv
// Instruction fetch front end.
// Issues handshaked word fetches to a variable-latency instruction memory,
// holds the returned words with their PCs in a small prefetch FIFO, and
// throws away in-flight and buffered words when execute redirects the PC.
module ifetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  logic [31:0]   buf_ins_q [DEPTH];
  logic [31:0]   buf_pc_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          ack_acc;
  logic          push;
  logic          pop;
  logic          slot_free;
  logic [31:0]   redirect_pc_al;
  logic [31:0]   fetch_pc_inc;
  logic          redirect_lsb_unused;

  // Low PC bits from execute carry no information for word fetches.
  assign redirect_pc_al      = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];
  assign fetch_pc_inc        = fetch_pc_q + 32'd4;

  // An ack only counts while a request is actually being presented.
  assign ack_acc = mem_req_q & mem_ack;
  assign pop     = ins_valid & ins_ready;
  // Words returned for a request that a redirect has overtaken are dropped.
  assign push    = (state_q == REQ) & ack_acc & ~redirect;

  // Occupancy after this cycle; a slot is free only if it stays below DEPTH,
  // which reserves room for the single outstanding request.
  assign slot_free = (count_d < CW'(DEPTH));

  assign ins_valid = (count_q != '0);
  assign ins       = buf_ins_q[rd_ptr_q];
  assign ins_pc    = buf_pc_q[rd_ptr_q];
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  // FIFO bookkeeping: redirect flushes everything, otherwise push/pop step the pointers.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch sequencer: decides when to present a request and where the next PC goes.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
        end else if (slot_free) begin
          mem_addr_d = fetch_pc_q;
          mem_req_d  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (ack_acc) begin
          if (redirect) begin
            fetch_pc_d = redirect_pc_al;
            mem_req_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            fetch_pc_d = fetch_pc_inc;
            if (slot_free) begin
              mem_addr_d = fetch_pc_inc;
            end else begin
              mem_req_d = 1'b0;
              state_d   = IDLE;
            end
          end
        end else if (redirect) begin
          // Request stays presented until the memory answers it.
          fetch_pc_d = redirect_pc_al;
          state_d    = DROP;
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
        end
        if (ack_acc) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Sequencer and memory interface registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage: each entry keeps the word together with the PC it came from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_ins_q[i] <= '0;
        buf_pc_q[i]  <= '0;
      end
    end else if (push) begin
      buf_ins_q[wr_ptr_q] <= mem_rdata;
      buf_pc_q[wr_ptr_q]  <= fetch_pc_q;
    end
  end

endmodule
